link_rx: RTL
============

# link_rx

Serial receiver that sits directly upstream of the master-board top level. It takes the single inter-board wire from the slave (player B) board and deserialises each framed status word. It then presents player B's 16-bit attack vector and control bits as stable, registered signals: `B`, `BTN1B`, `BTN2B`, `BTN3B`, `LivB`, `OKB`. Corrupt frames are rejected, and a watchdog forces all of player B's control bits to a safe state when the link goes silent.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clocks per serial bit (100 MHz / 115200). Legal values are at least 4.
- `TIMEOUT_CLKS`, default 10_000_000: clocks without a good frame before the link is declared down (100 ms).

Ports:
- `clk`, in, 1: system clock. All logic runs on the rising edge.
- `clr_n`, in, 1: reset. Asynchronous and active-low.
- `rx`, in, 1: serial line from the slave board. Asynchronous to `clk`; idles high.
- `B`, out, 16: last accepted attack vector from player B.
- `BTN1B`, `BTN2B`, `BTN3B`, out, 1 each: last accepted button levels from player B.
- `LivB`, out, 1: last accepted "player B alive" level.
- `OKB`, out, 1: last accepted player-B input-checker result.
- `frame_valid`, out, 1: one-cycle pulse when a good frame has been applied to the outputs.
- `frame_err`, out, 1: one-cycle pulse when a frame is rejected (parity or stop-bit error).
- `link_up`, out, 1: high while good frames keep arriving within `TIMEOUT_CLKS`.

## Operation
- **Input synchronisation:** `rx` passes through a 2-flop synchroniser (`rxs`). The FSM sees only `rxs`.
- **Frame format:** 24 bits, each lasting `CLKS_PER_BIT` clocks.
  - start = 0
  - payload bits d0..d20, LSB first: d0..d15 = `B[0..15]`, d16 = BTN1B, d17 = BTN2B, d18 = BTN3B, d19 = LivB, d20 = OKB
  - parity bit p, chosen so that d0..d20 plus p has even parity
  - stop = 1
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** on `rxs` = 0, go to START and load the bit counter with `CLKS_PER_BIT/2 - 1`.
  - **START:** at counter expiry (mid-bit), resample `rxs`.
    - If 1, treat it as a glitch and return to IDLE with no error pulse.
    - If 0, go to DATA with bit index 0 and counter `CLKS_PER_BIT - 1`.
  - **DATA:** sample at each expiry into a shift register. After d20, go to PARITY.
  - **PARITY:** sample p and go to STOP.
  - **STOP:** sample and go to IDLE.
    - The frame is good if stop = 1 and parity is even.
    - If good: load all payload outputs from the shift register, pulse `frame_valid`, reset the watchdog, and set `link_up` = 1.
    - If bad: payload outputs hold their values and `frame_err` pulses.
- **Atomic update:** payload outputs change only on a good frame, and all of them change on the same clock edge. Partial updates never occur.
- **Watchdog:** the counter increments every clock and saturates at `TIMEOUT_CLKS`. When it reaches `TIMEOUT_CLKS`:
  - `link_up` goes to 0.
  - BTN1B, BTN2B, BTN3B and OKB are forced to 0.
  - LivB is forced to 1, so that a dead link never reads as a player-B loss.
  - `B` holds its value.
  - The next good frame restores all outputs normally.
- **Reset mid-frame:** the FSM returns to IDLE, the shift register is cleared, and no pulse is issued. The frame in progress is discarded; the next start edge is honoured.

## Timing
- **Reset values:**
  - `B` = 0
  - BTN1B, BTN2B, BTN3B, OKB = 0
  - LivB = 1
  - `frame_valid`, `frame_err`, `link_up` = 0
  - FSM = IDLE; watchdog = 0
- **Latency:** outputs update, and `frame_valid` goes high, on the clock edge after the stop-bit mid-sample. That is about 23.5 × `CLKS_PER_BIT` + 3 clocks after the start falling edge reaches the `rx` pin, including 2 clocks of synchroniser delay.
- **Pulse width:** `frame_valid` and `frame_err` are exactly 1 cycle and never assert together.
- **Back-to-back frames:** a start bit immediately following a stop bit is accepted, because IDLE is re-entered right after the stop sample.
- **Watchdog tie-break:** if timeout expiry and a good frame occur in the same cycle, the good frame wins. `link_up` stays 1 and the outputs take the frame values.
- **Line held low:** if `rx` is held low continuously, the FSM reaches STOP, sees stop = 0, and pulses `frame_err`. It then re-enters START on the next cycle and repeats.

## Structure
- **Package `link_pkg`:**
  - `FRAME_PAYLOAD_BITS` = 21
  - payload bit-index localparams (`IDX_BTN1` = 16 … `IDX_OK` = 20)
  - `rx_state_t` enum {IDLE, START, DATA, PARITY, STOP}
- **Sub-module `sync2`:** a single-bit 2-flop synchroniser, reused for the raw button inputs elsewhere.
- **Top-level placement:** the top level instantiates `link_rx` and drives the existing player-B inputs from its outputs.

## Test plan
All tests use `CLKS_PER_BIT` = 8 and `TIMEOUT_CLKS` = 2000.
- **Good frame:** send `B` = 16'hA5C3 with BTN1B = 1, LivB = 1, OKB = 1, even parity. Expect one `frame_valid` pulse, then `B` = A5C3, BTN1B = 1, BTN2B = 0, BTN3B = 0, LivB = 1, OKB = 1, `link_up` = 1.
- **Parity error:** send 16'h0001 with p flipped. Expect one `frame_err` pulse; `B` holds A5C3; no `frame_valid`.
- **Stop-bit error:** send a good payload with stop = 0. Expect `frame_err`; outputs unchanged.
- **Glitch:** drive `rx` low for 2 clocks only. Expect no pulses and the FSM back in IDLE. A following good frame with 16'h8000 must be received correctly.
- **Timeout:** idle for 2000 clocks after a good frame. Expect `link_up` = 0, BTN1B..BTN3B = 0, OKB = 0, LivB = 1, `B` unchanged. The next good frame restores `link_up` = 1.
- **Reset during DATA:** assert `clr_n` = 0 at d7 of a frame. Expect all outputs at reset values immediately (asynchronously) and no pulses. After release, a full frame with 16'hFFFF must be received.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the inter-board serial link: payload layout and
// receiver state encoding.
package link_pkg;

  // Payload carried by one frame: 16-bit attack vector plus five control bits.
  localparam int FRAME_PAYLOAD_BITS = 21;
  localparam int B_WIDTH            = 16;

  // Bit positions of the control bits inside the payload.
  localparam int IDX_BTN1 = 16;
  localparam int IDX_BTN2 = 17;
  localparam int IDX_BTN3 = 18;
  localparam int IDX_LIV  = 19;
  localparam int IDX_OK   = 20;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // XOR of all payload bits; the transmitted parity bit equals this value
  // so that payload plus parity has even parity.
  function automatic logic payload_parity(input logic [FRAME_PAYLOAD_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync2.sv
// Single-bit two-flop synchroniser with a selectable reset level, used for
// asynchronous inputs such as the serial line and raw buttons.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/link_rx.sv
// Receiver for player B's status frames arriving over the single inter-board
// wire. Frame: start(0), 21 payload bits LSB first, even-parity bit, stop(1).
// Good frames update all player-B outputs atomically; a watchdog drives the
// control bits to a safe state if good frames stop arriving.
//
// Handshake: there is no back-pressure. frame_valid is a one-cycle strobe on
// the same edge the payload outputs change; frame_err is a one-cycle strobe
// for a rejected frame. The two never assert together.
module link_rx
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               rx,
  output logic [B_WIDTH-1:0] B,
  output logic               BTN1B,
  output logic               BTN2B,
  output logic               BTN3B,
  output logic               LivB,
  output logic               OKB,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               link_up,
  output rx_state_t          state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int WW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0]    DATA_LAST = 5'(FRAME_PAYLOAD_BITS - 1);
  localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CLKS);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CLKS - 1);

  logic                          rxs;
  logic [CW-1:0]                 cnt;
  logic [4:0]                    bit_idx;
  logic [FRAME_PAYLOAD_BITS-1:0] shreg;
  logic                          par_q;
  logic [WW-1:0]                 wd;

  logic sample;
  logic stop_sample;
  logic accept;
  logic reject;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (rx),
    .q     (rxs)
  );

  // Frame verdict is formed at the stop-bit mid-sample.
  always_comb begin
    sample      = (cnt == '0);
    stop_sample = (state == STOP) && sample;
    accept      = stop_sample && rxs && !(payload_parity(shreg) ^ par_q);
    reject      = stop_sample && !accept;
  end

  // Receive FSM: mid-bit sampling, shift register and result strobes.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_q       <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= accept;
      frame_err   <= reject;
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= HALF_LAST;
          end
        end
        START: begin
          if (sample) begin
            if (rxs) begin
              // Line back high at mid-start: a glitch, drop it silently.
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
              cnt     <= BIT_LAST;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (sample) begin
            shreg <= {rxs, shreg[FRAME_PAYLOAD_BITS-1:1]};
            cnt   <= BIT_LAST;
            if (bit_idx == DATA_LAST) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PARITY: begin
          if (sample) begin
            par_q <= rxs;
            cnt   <= BIT_LAST;
            state <= STOP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          // Returning to IDLE straight after the sample lets a start bit
          // that immediately follows the stop bit be caught.
          if (sample) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Player-B outputs and watchdog. A good frame takes priority over an
  // expiring watchdog in the same cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      B       <= '0;
      BTN1B   <= 1'b0;
      BTN2B   <= 1'b0;
      BTN3B   <= 1'b0;
      LivB    <= 1'b1;
      OKB     <= 1'b0;
      link_up <= 1'b0;
      wd      <= '0;
    end else if (accept) begin
      B       <= shreg[B_WIDTH-1:0];
      BTN1B   <= shreg[IDX_BTN1];
      BTN2B   <= shreg[IDX_BTN2];
      BTN3B   <= shreg[IDX_BTN3];
      LivB    <= shreg[IDX_LIV];
      OKB     <= shreg[IDX_OK];
      link_up <= 1'b1;
      wd      <= '0;
    end else if (wd != WD_MAX) begin
      wd <= wd + WW'(1);
      if (wd == WD_LAST) begin
        // Dead link: buttons released, checker not OK, and player B kept
        // "alive" so silence never reads as a loss. B keeps its last value.
        link_up <= 1'b0;
        BTN1B   <= 1'b0;
        BTN2B   <= 1'b0;
        BTN3B   <= 1'b0;
        OKB     <= 1'b0;
        LivB    <= 1'b1;
      end
    end
  end

endmodule
